nand_op_sequencer: RTL
======================

Name: nand_op_sequencer

Overview:
- Multi-cycle initiator that drives the CPU's combinational 8-bit NAND unit and builds the full logic instruction set from NAND passes: NAND, NOT, AND, OR, XOR and NOR.
- Accepts one command over a valid/ready handshake, issues one NAND pass per clock on the external NAND port pair, and holds the result until it is consumed.
- Sits between instruction decode and the register writeback path.

Parameters:
- WIDTH, 8, operand/result width; must match the NAND unit width.

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- cmd_valid  input  1  command present
- cmd_ready  output  1  sequencer can accept a command
- cmd_op  input  3  opcode: 000 NAND, 001 NOT(a), 010 AND, 011 OR, 100 XOR, 101 NOR, 110/111 illegal
- cmd_a  input  WIDTH  operand A
- cmd_b  input  WIDTH  operand B (ignored for NOT)
- nand_in1  output  WIDTH  first operand to the external NAND unit
- nand_in2  output  WIDTH  second operand to the external NAND unit
- nand_out  input  WIDTH  NAND result, combinational and valid in the same cycle
- res_valid  output  1  result present
- res_ready  input  1  consumer takes the result
- res_data  output  WIDTH  result
- res_err  output  1  result is from an illegal opcode
- busy  output  1  high whenever the state is not IDLE

Behaviour:
- Reset: async on rst_n=0. State IDLE; cmd_ready=1, res_valid=0, res_data=0, res_err=0, busy=0, nand_in1/nand_in2=0. All internal registers (opa, opb, t0, t1, step, op) clear to 0.
- States:
  - IDLE: cmd_ready=1.
  - EXEC: one NAND pass per cycle; step counts 0..N-1.
  - DONE: res_valid=1.
- Accept: a command is taken on a rising edge with cmd_valid & cmd_ready. cmd_op, cmd_a and cmd_b are latched into op, opa and opb. Later changes on the cmd_* inputs are ignored.
  - Legal opcode: go to EXEC, step=0.
  - Illegal opcode: go straight to DONE with res_data=0 and res_err=1.
- Pass schedule. Each step lists (nand_in1, nand_in2) -> destination. Capture into the destination happens at the end of that cycle.
  - NAND (N=1): (opa,opb) -> res
  - NOT (N=1): (opa,opa) -> res
  - AND (N=2): (opa,opb) -> t0; (t0,t0) -> res
  - OR (N=3): (opa,opa) -> t0; (opb,opb) -> t1; (t0,t1) -> res
  - XOR (N=4): (opa,opb) -> t0; (opa,t0) -> t1; (opb,t0) -> t0; (t1,t0) -> res
  - NOR (N=4): the three OR passes, with the third pass captured into t0; then (t0,t0) -> res
- Last step: the edge ending the last step loads res_data from nand_out, sets res_err=0 and moves to DONE.
- NAND port outputs: nand_in1/nand_in2 are driven from the schedule only in EXEC. They are 0 in IDLE and DONE.
- Latency: the result is visible N cycles after the accept edge. Illegal opcodes take 1 cycle.
- Handshake:
  - DONE holds res_data and res_err stable until res_valid & res_ready on a rising edge, then returns to IDLE.
  - res_ready while not in DONE has no effect.
  - cmd_ready is low in EXEC and DONE. The next accept is therefore possible one cycle after the result is consumed.
  - res_data is not cleared on consume; it holds its last value while res_valid=0.
- Simultaneous events: cmd_valid during EXEC/DONE is not accepted. The command must be held by the source.
- Reset mid-operation: async reset in any state aborts the operation. The partial result is discarded and no res_valid is produced.
- Width rules: all operations are bitwise and WIDTH-wide, with no carries. The step counter is 2 bits and never wraps past N-1.

Decomposition:
- Shared include logic_op_defs.vh holds:
  - opcode constants OP_NAND..OP_NOR
  - state encodings ST_IDLE, ST_EXEC, ST_DONE
  - per-op pass counts
- Sub-module nand_step_decode is combinational:
  - inputs: (op, step)
  - outputs: in1_sel and in2_sel (each one of opa, opb, t0, t1), dst_sel (t0, t1 or res), and last
- The sequencer keeps the FSM and all registers. The bench connects the real Nander model to the nand_* ports.

Test Plan:
- Reset then idle: rst_n low mid-sim -> cmd_ready=1, res_valid=0, res_data=0, nand_in1/nand_in2=0 immediately, without waiting for a clock edge.
- All ops with a=0xCC, b=0xAA, res_ready held high -> NAND 0x77, NOT 0x33, AND 0x88, OR 0xEE, XOR 0x66, NOR 0x11. Each must appear exactly 1/1/2/3/4/4 cycles after accept, with res_err=0.
- Illegal op 3'b110 -> res_valid one cycle after accept, res_data=0x00, res_err=1. The NAND ports stay 0 throughout.
- Backpressure: XOR of 0xF0 and 0x3C with res_ready low for 5 cycles -> res_valid=1 and res_data=0xCC held stable, cmd_ready=0 throughout. Raising res_ready gives a single-cycle consume, then cmd_ready=1.
- Operand isolation: change cmd_a/cmd_b and hold cmd_valid=1 during an OR of 0x0F and 0x30 -> result 0x3F. The second command is accepted only after the first is consumed.
- Reset mid-XOR at step 2 -> state IDLE and no res_valid. A following NAND of 0xFF and 0xFF returns 0x00 with correct 1-cycle latency.

Source files
------------

// File: rtl/nand_op_sequencer_pkg.sv
// Shared opcodes, state encoding, pass counts and operand/destination selects
// for the NAND-based logic-op sequencer.
package nand_op_sequencer_pkg;

  localparam int unsigned OP_W   = 3;
  localparam int unsigned STEP_W = 2;

  localparam logic [OP_W-1:0] OP_NAND = 3'd0;
  localparam logic [OP_W-1:0] OP_NOT  = 3'd1;
  localparam logic [OP_W-1:0] OP_AND  = 3'd2;
  localparam logic [OP_W-1:0] OP_OR   = 3'd3;
  localparam logic [OP_W-1:0] OP_XOR  = 3'd4;
  localparam logic [OP_W-1:0] OP_NOR  = 3'd5;

  localparam int unsigned PASSES_NAND = 1;
  localparam int unsigned PASSES_NOT  = 1;
  localparam int unsigned PASSES_AND  = 2;
  localparam int unsigned PASSES_OR   = 3;
  localparam int unsigned PASSES_XOR  = 4;
  localparam int unsigned PASSES_NOR  = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    SEL_OPA = 2'd0,
    SEL_OPB = 2'd1,
    SEL_T0  = 2'd2,
    SEL_T1  = 2'd3
  } src_sel_e;

  typedef enum logic [1:0] {
    DST_T0  = 2'd0,
    DST_T1  = 2'd1,
    DST_RES = 2'd2
  } dst_sel_e;

  function automatic logic op_legal(input logic [OP_W-1:0] op);
    return op <= OP_NOR;
  endfunction

  // Index of the final pass for an opcode; illegal opcodes never reach EXEC.
  function automatic logic [STEP_W-1:0] last_step(input logic [OP_W-1:0] op);
    case (op)
      OP_NAND: return STEP_W'(PASSES_NAND - 1);
      OP_NOT:  return STEP_W'(PASSES_NOT - 1);
      OP_AND:  return STEP_W'(PASSES_AND - 1);
      OP_OR:   return STEP_W'(PASSES_OR - 1);
      OP_XOR:  return STEP_W'(PASSES_XOR - 1);
      OP_NOR:  return STEP_W'(PASSES_NOR - 1);
      default: return '0;
    endcase
  endfunction

endpackage

// File: rtl/nand_step_decode.sv
// Combinational pass schedule: for (op, step) selects the two NAND operands,
// the capture destination and whether this is the final pass.
module nand_step_decode
  import nand_op_sequencer_pkg::*;
(
  input  logic [OP_W-1:0]   op,
  input  logic [STEP_W-1:0] step,
  output src_sel_e          in1_sel,
  output src_sel_e          in2_sel,
  output dst_sel_e          dst_sel,
  output logic              last
);

  always_comb begin
    in1_sel = SEL_OPA;
    in2_sel = SEL_OPA;
    dst_sel = DST_RES;
    last    = (step == last_step(op));
    case (op)
      OP_NAND: in2_sel = SEL_OPB;
      OP_NOT:  ;
      OP_AND: begin
        case (step)
          2'd0: begin in2_sel = SEL_OPB; dst_sel = DST_T0; end
          default: begin in1_sel = SEL_T0; in2_sel = SEL_T0; end
        endcase
      end
      OP_OR, OP_NOR: begin
        case (step)
          2'd0: dst_sel = DST_T0;
          2'd1: begin in1_sel = SEL_OPB; in2_sel = SEL_OPB; dst_sel = DST_T1; end
          2'd2: begin
            in1_sel = SEL_T0;
            in2_sel = SEL_T1;
            // NOR keeps the OR result in t0 for the final inversion pass
            dst_sel = (op == OP_NOR) ? DST_T0 : DST_RES;
          end
          default: begin in1_sel = SEL_T0; in2_sel = SEL_T0; end
        endcase
      end
      OP_XOR: begin
        case (step)
          2'd0: begin in2_sel = SEL_OPB; dst_sel = DST_T0; end
          2'd1: begin in2_sel = SEL_T0; dst_sel = DST_T1; end
          2'd2: begin in1_sel = SEL_OPB; in2_sel = SEL_T0; dst_sel = DST_T0; end
          default: begin in1_sel = SEL_T1; in2_sel = SEL_T0; end
        endcase
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/nand_op_sequencer.sv
// Multi-cycle initiator that builds NAND/NOT/AND/OR/XOR/NOR from one external
// NAND pass per clock, with valid/ready command and result handshakes.
module nand_op_sequencer
  import nand_op_sequencer_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [OP_W-1:0]  cmd_op,
  input  logic [WIDTH-1:0] cmd_a,
  input  logic [WIDTH-1:0] cmd_b,
  output logic [WIDTH-1:0] nand_in1,
  output logic [WIDTH-1:0] nand_in2,
  input  logic [WIDTH-1:0] nand_out,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_data,
  output logic             res_err,
  output logic             busy
);

  state_e            state_q, state_d;
  logic [OP_W-1:0]   op_q, op_d;
  logic [STEP_W-1:0] step_q, step_d;
  logic [WIDTH-1:0]  opa_q, opa_d, opb_q, opb_d;
  logic [WIDTH-1:0]  t0_q, t0_d, t1_q, t1_d;
  logic [WIDTH-1:0]  res_data_q, res_data_d;
  logic              res_err_q, res_err_d;
  logic              res_valid_q, cmd_ready_q, busy_q;
  logic [WIDTH-1:0]  nand_in1_q, nand_in1_d, nand_in2_q, nand_in2_d;
  dst_sel_e          dst_q, dst_d;
  logic              last_q, last_d;
  src_sel_e          in1_sel, in2_sel;

  assign cmd_ready = cmd_ready_q;
  assign res_valid = res_valid_q;
  assign res_data  = res_data_q;
  assign res_err   = res_err_q;
  assign busy      = busy_q;
  assign nand_in1  = nand_in1_q;
  assign nand_in2  = nand_in2_q;

  function automatic logic [WIDTH-1:0] pick(input src_sel_e sel,
                                            input logic [WIDTH-1:0] a,
                                            input logic [WIDTH-1:0] b,
                                            input logic [WIDTH-1:0] x,
                                            input logic [WIDTH-1:0] y);
    case (sel)
      SEL_OPA: return a;
      SEL_OPB: return b;
      SEL_T0:  return x;
      default: return y;
    endcase
  endfunction

  // Decode the pass that runs next cycle so the NAND ports can be registered.
  nand_step_decode u_decode (
    .op      (op_d),
    .step    (step_d),
    .in1_sel (in1_sel),
    .in2_sel (in2_sel),
    .dst_sel (dst_d),
    .last    (last_d)
  );

  always_comb begin : next_state
    state_d    = state_q;
    op_d       = op_q;
    opa_d      = opa_q;
    opb_d      = opb_q;
    t0_d       = t0_q;
    t1_d       = t1_q;
    step_d     = step_q;
    res_data_d = res_data_q;
    res_err_d  = res_err_q;
    case (state_q)
      ST_IDLE: begin
        if (cmd_valid && cmd_ready_q) begin
          op_d   = cmd_op;
          opa_d  = cmd_a;
          opb_d  = cmd_b;
          step_d = '0;
          if (op_legal(cmd_op)) begin
            state_d = ST_EXEC;
          end else begin
            state_d    = ST_DONE;
            res_data_d = '0;
            res_err_d  = 1'b1;
          end
        end
      end
      ST_EXEC: begin
        case (dst_q)
          DST_T0:  t0_d = nand_out;
          DST_T1:  t1_d = nand_out;
          default: ;
        endcase
        if (last_q) begin
          res_data_d = nand_out;
          res_err_d  = 1'b0;
          state_d    = ST_DONE;
        end else begin
          step_d = step_q + 2'd1;
        end
      end
      ST_DONE: begin
        if (res_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin : port_next
    nand_in1_d = '0;
    nand_in2_d = '0;
    if (state_d == ST_EXEC) begin
      nand_in1_d = pick(in1_sel, opa_d, opb_d, t0_d, t1_d);
      nand_in2_d = pick(in2_sel, opa_d, opb_d, t0_d, t1_d);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      op_q        <= '0;
      step_q      <= '0;
      opa_q       <= '0;
      opb_q       <= '0;
      t0_q        <= '0;
      t1_q        <= '0;
      res_data_q  <= '0;
      res_err_q   <= 1'b0;
      res_valid_q <= 1'b0;
      cmd_ready_q <= 1'b1;
      busy_q      <= 1'b0;
      nand_in1_q  <= '0;
      nand_in2_q  <= '0;
      dst_q       <= DST_T0;
      last_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      step_q      <= step_d;
      opa_q       <= opa_d;
      opb_q       <= opb_d;
      t0_q        <= t0_d;
      t1_q        <= t1_d;
      res_data_q  <= res_data_d;
      res_err_q   <= res_err_d;
      res_valid_q <= (state_d == ST_DONE);
      cmd_ready_q <= (state_d == ST_IDLE);
      busy_q      <= (state_d != ST_IDLE);
      nand_in1_q  <= nand_in1_d;
      nand_in2_q  <= nand_in2_d;
      dst_q       <= dst_d;
      last_q      <= last_d;
    end
  end

endmodule
